// File: rtl/seg_pkg.sv
// seg_pkg: shared 7-segment pattern constants.
// The values are the active-low seg_n patterns (bit0=a .. bit6=g, 0=lit)
// that the matching hex-to-segment display encoder drives, so the reader and
// the encoder agree on one table.
package seg_pkg;

   localparam int SEG_W = 7;

   localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
   localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
   localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
   localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
   localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
   localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
   localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
   localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
   localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
   localparam logic [SEG_W-1:0] SEG_9     = 7'h18;
   localparam logic [SEG_W-1:0] SEG_A     = 7'h08;
   localparam logic [SEG_W-1:0] SEG_B     = 7'h03;
   localparam logic [SEG_W-1:0] SEG_C     = 7'h46;
   localparam logic [SEG_W-1:0] SEG_D     = 7'h21;
   localparam logic [SEG_W-1:0] SEG_E     = 7'h06;
   localparam logic [SEG_W-1:0] SEG_F     = 7'h0e;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7f;

endpackage

// File: rtl/seg_pattern_lookup.sv
// seg_pattern_lookup: combinational reverse lookup of one active-low
// 7-segment pattern.
// Ports:
//   seg_n    in  [6:0]  segment lines, 0 = lit
//   nibble   out [3:0]  recovered hex value (0 when not a hex pattern)
//   is_hex   out        pattern is one of the 16 hex glyphs
//   is_blank out        pattern is all segments off
// A pattern with is_hex=0 and is_blank=0 is unrecognised.
module seg_pattern_lookup
   import seg_pkg::*;
(
   input  logic [SEG_W-1:0] seg_n,
   output logic [3:0]       nibble,
   output logic             is_hex,
   output logic             is_blank
);

   always_comb begin
      nibble   = 4'h0;
      is_hex   = 1'b1;
      is_blank = 1'b0;
      case (seg_n)
         SEG_0:     nibble = 4'h0;
         SEG_1:     nibble = 4'h1;
         SEG_2:     nibble = 4'h2;
         SEG_3:     nibble = 4'h3;
         SEG_4:     nibble = 4'h4;
         SEG_5:     nibble = 4'h5;
         SEG_6:     nibble = 4'h6;
         SEG_7:     nibble = 4'h7;
         SEG_8:     nibble = 4'h8;
         SEG_9:     nibble = 4'h9;
         SEG_A:     nibble = 4'ha;
         SEG_B:     nibble = 4'hb;
         SEG_C:     nibble = 4'hc;
         SEG_D:     nibble = 4'hd;
         SEG_E:     nibble = 4'he;
         SEG_F:     nibble = 4'hf;
         SEG_BLANK: begin
            is_hex   = 1'b0;
            is_blank = 1'b1;
         end
         default:   is_hex = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_scan_reader.sv
// seg_scan_reader: recovers per-digit hex values from a multiplexed,
// active-low 7-segment display bus, with per-digit stability filtering.
// Ports:
//   clock, resetn     clock (rising edge) and synchronous active-low reset
//   seg_valid         sample strobe for seg_n / dig_sel
//   seg_n [6:0]       segment lines, bit0=a .. bit6=g, 0 = lit
//   dig_sel [N-1:0]   one-hot digit position of the current sample
//   hex_flat [4N-1:0] recovered nibbles, digit i at [4i+3:4i]
//   digit_valid/blank/err [N-1:0]  class of each digit's accepted pattern
//   upd, upd_idx      one-cycle pulse + index when a digit's accepted state changes
//   sel_err           one-cycle pulse when a strobed dig_sel is not one-hot
// A pattern is accepted only after STABLE_COUNT consecutive identical samples
// on that digit; all outputs are registered on the committing edge.
module seg_scan_reader
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS   = 6,
   parameter int STABLE_COUNT = 3,
   localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                    clock,
   input  logic                    resetn,
   input  logic                    seg_valid,
   input  logic [SEG_W-1:0]        seg_n,
   input  logic [NUM_DIGITS-1:0]   dig_sel,
   output logic [4*NUM_DIGITS-1:0] hex_flat,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic [NUM_DIGITS-1:0]   digit_blank,
   output logic [NUM_DIGITS-1:0]   digit_err,
   output logic                    upd,
   output logic [IDX_W-1:0]        upd_idx,
   output logic                    sel_err
);

   localparam int              CNT_W   = $clog2(STABLE_COUNT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_COUNT);

   logic [NUM_DIGITS-1:0] sel_minus_one;
   logic                  sel_onehot;
   logic [3:0]            lk_nibble;
   logic                  lk_hex;
   logic                  lk_blank;
   logic [NUM_DIGITS-1:0] commit;

   // x & (x-1) clears the lowest set bit: zero result means at most one bit set.
   assign sel_minus_one = dig_sel - NUM_DIGITS'(1);
   assign sel_onehot    = (dig_sel != '0) && ((dig_sel & sel_minus_one) == '0);

   // Only one digit is sampled per cycle, so a single decoder serves all digits.
   seg_pattern_lookup u_lookup (
      .seg_n    (seg_n),
      .nibble   (lk_nibble),
      .is_hex   (lk_hex),
      .is_blank (lk_blank)
   );

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      logic [SEG_W-1:0] cand_q, cand_d;
      logic [SEG_W-1:0] acc_q, acc_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [3:0]       hex_q, hex_d;
      logic             valid_q, valid_d;
      logic             blank_q, blank_d;
      logic             err_q, err_d;
      logic             hit;
      logic             commit_i;

      assign hit = seg_valid && sel_onehot && dig_sel[i];

      always_comb begin
         cand_d   = cand_q;
         cnt_d    = cnt_q;
         acc_d    = acc_q;
         hex_d    = hex_q;
         valid_d  = valid_q;
         blank_d  = blank_q;
         err_d    = err_q;
         commit_i = 1'b0;
         if (hit) begin
            if (seg_n != cand_q) begin
               cand_d = seg_n;
               cnt_d  = CNT_W'(1);
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            // Re-confirming the already accepted pattern is silent.
            if ((cnt_d == CNT_MAX) && (seg_n != acc_q)) begin
               commit_i = 1'b1;
               acc_d    = seg_n;
               blank_d  = lk_blank;
               valid_d  = lk_hex;
               err_d    = !lk_hex && !lk_blank;
               // Blank and error keep the last recovered nibble.
               if (lk_hex) begin
                  hex_d = lk_nibble;
               end
            end
         end
      end

      always_ff @(posedge clock) begin
         if (!resetn) begin
            cand_q  <= SEG_BLANK;
            acc_q   <= SEG_BLANK;
            cnt_q   <= '0;
            hex_q   <= 4'h0;
            valid_q <= 1'b0;
            blank_q <= 1'b0;
            err_q   <= 1'b0;
         end else begin
            cand_q  <= cand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            hex_q   <= hex_d;
            valid_q <= valid_d;
            blank_q <= blank_d;
            err_q   <= err_d;
         end
      end

      assign commit[i]         = commit_i;
      assign hex_flat[4*i +: 4] = hex_q;
      assign digit_valid[i]    = valid_q;
      assign digit_blank[i]    = blank_q;
      assign digit_err[i]      = err_q;
   end

   logic             upd_q, upd_d;
   logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
   logic             sel_err_q, sel_err_d;

   always_comb begin
      upd_d     = |commit;
      upd_idx_d = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (commit[k]) begin
            upd_idx_d = IDX_W'(k);
         end
      end
      sel_err_d = seg_valid && !sel_onehot;
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         upd_q     <= 1'b0;
         upd_idx_q <= '0;
         sel_err_q <= 1'b0;
      end else begin
         upd_q     <= upd_d;
         upd_idx_q <= upd_idx_d;
         sel_err_q <= sel_err_d;
      end
   end

   assign upd     = upd_q;
   assign upd_idx = upd_idx_q;
   assign sel_err = sel_err_q;

endmodule

// File: tb/tb_seg_scan_reader.sv
// tb_seg_scan_reader: self-checking bench for seg_scan_reader (6 digits,
// STABLE_COUNT=3). A behavioural model tracks, per digit, the current run of
// identical samples and the accepted pattern; a pattern is accepted once its
// run reaches STABLE_COUNT and it differs from the accepted one.
module tb_seg_scan_reader;

   localparam int ND = 6;
   localparam int SC = 3;
   localparam int IW = 3;

   logic            clock = 1'b0;
   logic            resetn;
   logic            seg_valid;
   logic [6:0]      seg_n;
   logic [ND-1:0]   dig_sel;
   logic [4*ND-1:0] hex_flat;
   logic [ND-1:0]   digit_valid;
   logic [ND-1:0]   digit_blank;
   logic [ND-1:0]   digit_err;
   logic            upd;
   logic [IW-1:0]   upd_idx;
   logic            sel_err;

   seg_scan_reader #(.NUM_DIGITS(ND), .STABLE_COUNT(SC)) dut (
      .clock       (clock),
      .resetn      (resetn),
      .seg_valid   (seg_valid),
      .seg_n       (seg_n),
      .dig_sel     (dig_sel),
      .hex_flat    (hex_flat),
      .digit_valid (digit_valid),
      .digit_blank (digit_blank),
      .digit_err   (digit_err),
      .upd         (upd),
      .upd_idx     (upd_idx),
      .sel_err     (sel_err)
   );

   // clock / reset block
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   int checks = 0;
   int errors = 0;

   // ---------------- reference model ----------------
   logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e};
   logic [6:0]      m_last [ND];
   logic [6:0]      m_acc  [ND];
   int              m_run  [ND];
   logic [4*ND-1:0] m_hex;
   logic [ND-1:0]   m_valid, m_blank, m_err;
   logic            m_upd, m_sel_err;
   logic [IW-1:0]   m_upd_idx;

   // 0..15 = hex value, 16 = blank, -1 = unrecognised
   function automatic int decode(input logic [6:0] p);
      int r;
      r = -1;
      for (int i = 0; i < 16; i++) if (tbl[i] == p) r = i;
      if (p == 7'h7f) r = 16;
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < ND; i++) begin
         m_last[i] = 7'h7f;
         m_acc[i]  = 7'h7f;
         m_run[i]  = 0;
      end
      m_hex = '0; m_valid = '0; m_blank = '0; m_err = '0;
      m_upd = 1'b0; m_sel_err = 1'b0; m_upd_idx = '0;
   endtask

   task automatic model_sample(input logic v, input logic [ND-1:0] sel, input logic [6:0] seg);
      int d;
      int code;
      m_upd     = 1'b0;
      m_sel_err = 1'b0;
      if (!v) return;
      if ($countones(sel) != 1) begin
         m_sel_err = 1'b1;
         return;
      end
      d = 0;
      for (int i = 0; i < ND; i++) if (sel[i]) d = i;
      if (m_run[d] > 0 && seg == m_last[d]) m_run[d]++;
      else begin
         m_last[d] = seg;
         m_run[d]  = 1;
      end
      if (m_run[d] >= SC && seg != m_acc[d]) begin
         m_acc[d]  = seg;
         m_upd     = 1'b1;
         m_upd_idx = IW'(d);
         code      = decode(seg);
         m_valid[d] = 1'b0; m_blank[d] = 1'b0; m_err[d] = 1'b0;
         if (code >= 0 && code < 16) begin
            m_hex[4*d +: 4] = 4'(code);
            m_valid[d] = 1'b1;
         end else if (code == 16) m_blank[d] = 1'b1;
         else m_err[d] = 1'b1;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step(input logic v, input logic [ND-1:0] sel, input logic [6:0] seg);
      seg_valid = v;
      dig_sel   = sel;
      seg_n     = seg;
      @(posedge clock);
      model_sample(v, sel, seg);
      #1;
      seg_valid = 1'b0;
   endtask

   task automatic do_reset(input int n);
      resetn    = 1'b0;
      seg_valid = 1'b0;
      repeat (n) @(posedge clock);
      model_reset();
      #1;
      resetn = 1'b1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset(2);
      checks++; if (hex_flat !== '0) begin errors++; $display("FAIL reset_hex got %h exp 0", hex_flat); end
      checks++; if (digit_valid !== '0) begin errors++; $display("FAIL reset_valid got %b exp 0", digit_valid); end
      checks++; if (digit_blank !== '0) begin errors++; $display("FAIL reset_blank got %b exp 0", digit_blank); end
      checks++; if (digit_err !== '0) begin errors++; $display("FAIL reset_err got %b exp 0", digit_err); end
      checks++; if (upd !== 1'b0 || upd_idx !== '0) begin errors++; $display("FAIL reset_upd got %b/%0d exp 0/0", upd, upd_idx); end
      checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err got %b exp 0", sel_err); end
   endtask

   task automatic test_basic();
      for (int k = 1; k <= 4; k++) begin
         step(1'b1, 6'b000100, 7'h30);
         if (k == 3) begin
            checks++; if (hex_flat[11:8] !== 4'h3) begin errors++; $display("FAIL basic_hex got %h exp 3", hex_flat[11:8]); end
            checks++; if (digit_valid[2] !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", digit_valid[2]); end
            checks++; if (upd !== 1'b1 || upd_idx !== 3'd2) begin errors++; $display("FAIL basic_upd got %b/%0d exp 1/2", upd, upd_idx); end
         end else begin
            checks++; if (upd !== 1'b0) begin errors++; $display("FAIL basic_noupd_%0d got %b exp 0", k, upd); end
            if (k < 3) begin
               checks++; if (digit_valid[2] !== 1'b0) begin errors++; $display("FAIL basic_early_%0d got %b exp 0", k, digit_valid[2]); end
            end
         end
      end
      checks++; if (hex_flat !== m_hex) begin errors++; $display("FAIL basic_model_hex got %h exp %h", hex_flat, m_hex); end
   endtask

   task automatic test_glitch();
      logic [6:0] g [5];
      int ups;
      g = '{7'h40, 7'h40, 7'h79, 7'h79, 7'h79};
      ups = 0;
      for (int k = 0; k < 5; k++) begin
         step(1'b1, 6'b000001, g[k]);
         if (upd === 1'b1) ups++;
         if (k < 4) begin
            checks++; if (digit_valid[0] !== 1'b0) begin errors++; $display("FAIL glitch_early_%0d got %b exp 0", k, digit_valid[0]); end
         end
      end
      checks++; if (hex_flat[3:0] !== 4'h1) begin errors++; $display("FAIL glitch_hex got %h exp 1", hex_flat[3:0]); end
      checks++; if (digit_valid[0] !== 1'b1) begin errors++; $display("FAIL glitch_valid got %b exp 1", digit_valid[0]); end
      checks++; if (ups != 1 || upd !== 1'b1) begin errors++; $display("FAIL glitch_upd got count %0d last %b exp 1/1", ups, upd); end
   endtask

   task automatic test_invalid();
      repeat (3) step(1'b1, 6'b000010, 7'h08);
      checks++; if (hex_flat[7:4] !== 4'ha || digit_valid[1] !== 1'b1) begin errors++; $display("FAIL inv_a got %h/%b exp a/1", hex_flat[7:4], digit_valid[1]); end
      repeat (3) step(1'b1, 6'b000010, 7'h7e);
      checks++; if (digit_err[1] !== 1'b1) begin errors++; $display("FAIL inv_err got %b exp 1", digit_err[1]); end
      checks++; if (digit_valid[1] !== 1'b0) begin errors++; $display("FAIL inv_valid got %b exp 0", digit_valid[1]); end
      checks++; if (hex_flat[7:4] !== 4'ha) begin errors++; $display("FAIL inv_hold got %h exp a", hex_flat[7:4]); end
      repeat (3) step(1'b1, 6'b000010, 7'h7f);
      checks++; if (digit_blank[1] !== 1'b1 || digit_err[1] !== 1'b0) begin errors++; $display("FAIL inv_blank got %b/%b exp 1/0", digit_blank[1], digit_err[1]); end
      checks++; if (hex_flat[7:4] !== 4'ha) begin errors++; $display("FAIL inv_blank_hold got %h exp a", hex_flat[7:4]); end
   endtask

   task automatic test_sel_err();
      step(1'b1, 6'b000011, 7'h18);
      checks++; if (sel_err !== 1'b1 || upd !== 1'b0) begin errors++; $display("FAIL selerr_multi got %b/%b exp 1/0", sel_err, upd); end
      step(1'b1, 6'b000000, 7'h18);
      checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL selerr_zero got %b exp 1", sel_err); end
      step(1'b0, 6'b000011, 7'h18);
      checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL selerr_novalid got %b exp 0", sel_err); end
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 6'b000001, 7'h18);
         checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL selerr_clear_%0d got %b exp 0", k, sel_err); end
         if (k < 2) begin
            checks++; if (upd !== 1'b0 || hex_flat[3:0] !== 4'h1) begin errors++; $display("FAIL selerr_nocommit_%0d got %b/%h exp 0/1", k, upd, hex_flat[3:0]); end
         end
      end
      checks++; if (upd !== 1'b1 || hex_flat[3:0] !== 4'h9) begin errors++; $display("FAIL selerr_commit got %b/%h exp 1/9", upd, hex_flat[3:0]); end
   endtask

   task automatic test_reset_mid();
      repeat (2) step(1'b1, 6'b010000, 7'h12);
      do_reset(1);
      checks++; if (hex_flat !== '0 || digit_valid !== '0) begin errors++; $display("FAIL rmid_reset got %h/%b exp 0/0", hex_flat, digit_valid); end
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 6'b010000, 7'h12);
         if (k < 2) begin
            checks++; if (upd !== 1'b0 || digit_valid[4] !== 1'b0) begin errors++; $display("FAIL rmid_nocommit_%0d got %b/%b exp 0/0", k, upd, digit_valid[4]); end
         end
      end
      checks++; if (upd !== 1'b1 || upd_idx !== 3'd4 || hex_flat[19:16] !== 4'h5) begin
         errors++; $display("FAIL rmid_commit got %b/%0d/%h exp 1/4/5", upd, upd_idx, hex_flat[19:16]);
      end
   endtask

   task automatic test_random();
      int d, len, idx;
      logic [6:0] p;
      logic [ND-1:0] sel;
      logic v;
      for (int it = 0; it < 400; it++) begin
         if ($urandom_range(0, 199) == 0) do_reset(1);
         d   = $urandom_range(0, ND - 1);
         idx = $urandom_range(0, 19);
         if (idx < 16) p = tbl[idx];
         else if (idx < 18) p = 7'h7f;
         else p = 7'($urandom_range(0, 127));
         len = $urandom_range(1, 4);
         for (int r = 0; r < len; r++) begin
            v   = ($urandom_range(0, 9) != 0);
            sel = ND'(1) << d;
            if ($urandom_range(0, 19) == 0) sel = ND'($urandom_range(0, 63));
            step(v, sel, p);
            checks++; if (hex_flat !== m_hex) begin errors++; $display("FAIL rnd_hex it%0d got %h exp %h", it, hex_flat, m_hex); end
            checks++; if (digit_valid !== m_valid || digit_blank !== m_blank || digit_err !== m_err) begin
               errors++; $display("FAIL rnd_flags it%0d got %b/%b/%b exp %b/%b/%b", it, digit_valid, digit_blank, digit_err, m_valid, m_blank, m_err);
            end
            checks++; if (upd !== m_upd || sel_err !== m_sel_err) begin errors++; $display("FAIL rnd_pulse it%0d got %b/%b exp %b/%b", it, upd, sel_err, m_upd, m_sel_err); end
            if (m_upd) begin
               checks++; if (upd_idx !== m_upd_idx) begin errors++; $display("FAIL rnd_idx it%0d got %0d exp %0d", it, upd_idx, m_upd_idx); end
            end
         end
      end
   endtask

   initial begin
      resetn    = 1'b0;
      seg_valid = 1'b0;
      seg_n     = 7'h7f;
      dig_sel   = '0;
      model_reset();
      test_reset();
      test_basic();
      test_glitch();
      test_invalid();
      test_sel_err();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
